// File: rtl/month_sequencer.sv
// rtl/month_sequencer.sv - calendar day/month/year sequencer driving a one-hot month decoder
module month_sequencer #(
  parameter int YEAR_MAX = 99,
  parameter bit LEAP_EN  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_load,
  input  logic [3:0]  i_load_month,
  input  logic [4:0]  i_load_day,
  input  logic [6:0]  i_load_year,
  output logic [11:0] o_month_oh,
  output logic [3:0]  o_month_idx,
  output logic [4:0]  o_day,
  output logic [6:0]  o_year,
  output logic        o_eom,
  output logic        o_eoy,
  output logic        o_load_err
);

  localparam logic [6:0] LP_YEAR_MAX = 7'(YEAR_MAX);

  logic [11:0] r_month_oh;
  logic [3:0]  r_month_idx;
  logic [4:0]  r_day;
  logic [6:0]  r_year;
  logic        r_eom;
  logic        r_eoy;
  logic        r_load_err;

  logic [4:0]  w_len_cur;
  logic [4:0]  w_len_load;
  logic        w_load_ok;

  // Days in month m of year y; an out-of-range month yields 0 so any day is rejected.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] len;
    case (m)
      4'd0, 4'd2, 4'd4, 4'd6, 4'd7, 4'd9, 4'd11: len = 5'd31;
      4'd3, 4'd5, 4'd8, 4'd10:                   len = 5'd30;
      4'd1:    len = (LEAP_EN && (y[1:0] == 2'b00)) ? 5'd29 : 5'd28;
      default: len = 5'd0;
    endcase
    return len;
  endfunction

  // Month lengths for the running date and for the candidate load, plus load validity.
  always_comb begin
    w_len_cur  = month_len(r_month_idx, r_year);
    w_len_load = month_len(i_load_month, i_load_year);
    w_load_ok  = (i_load_month <= 4'd11) && (i_load_day != 5'd0) &&
                 (i_load_day <= w_len_load) && (i_load_year <= LP_YEAR_MAX);
  end

  // Date state and pulse outputs; priority is reset, then load, then tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_month_oh  <= 12'h001;
      r_month_idx <= 4'd0;
      r_day       <= 5'd1;
      r_year      <= 7'd0;
      r_eom       <= 1'b0;
      r_eoy       <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_eom      <= 1'b0;
      r_eoy      <= 1'b0;
      r_load_err <= 1'b0;
      if (i_load) begin
        if (w_load_ok) begin
          r_month_idx <= i_load_month;
          r_month_oh  <= 12'h001 << i_load_month;
          r_day       <= i_load_day;
          r_year      <= i_load_year;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (i_tick) begin
        if (r_day < w_len_cur) begin
          r_day <= r_day + 5'd1;
        end else begin
          r_day      <= 5'd1;
          r_eom      <= 1'b1;
          // Rotation also covers Dec -> Jan since bit 11 wraps to bit 0.
          r_month_oh <= {r_month_oh[10:0], r_month_oh[11]};
          if (r_month_idx == 4'd11) begin
            r_month_idx <= 4'd0;
            r_eoy       <= 1'b1;
            r_year      <= (r_year == LP_YEAR_MAX) ? 7'd0 : r_year + 7'd1;
          end else begin
            r_month_idx <= r_month_idx + 4'd1;
          end
        end
      end
    end
  end

  assign o_month_oh  = r_month_oh;
  assign o_month_idx = r_month_idx;
  assign o_day       = r_day;
  assign o_year      = r_year;
  assign o_eom       = r_eom;
  assign o_eoy       = r_eoy;
  assign o_load_err  = r_load_err;

endmodule
